pipeline_flow_ctrl: RTL and testbench

Consumes the stall and flush requests raised by the hazard detection unit and turns them into per-stage write enables, bubble insertion and PC redirect for the 5-stage core. Also owns the IF/ID and ID/EX valid bits, and freezes the whole pipeline on instruction- and data-memory wait states. A flush raised during a data-memory wait is held pending until the wait ends. Saturating stall and flush event counters are exported for performance monitoring.

---
 rtl/pipeline_flow_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_flow_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline flow controller for the 5-stage core: turns hazard-unit stall/flush
// requests and memory wait states into stage enables, bubbles and PC redirects.
module pipeline_flow_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_pipeline,
  input  logic             flush_pipeline,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_write_en,
  output logic             pc_redirect_valid,
  output logic [XLEN-1:0]  pc_redirect,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             ex_mem_write_en,
  output logic             if_id_valid,
  output logic             id_ex_valid,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH_APPLY} state_t;

  state_t            state, state_nxt;
  logic              pend_flush, pend_flush_nxt;
  logic [XLEN-1:0]   pend_pc, pend_pc_nxt;
  logic              if_id_valid_nxt, id_ex_valid_nxt;
  logic              flush_applied;
  logic              run_decode;
  logic              pc_we, if_we, id_we, exm_we, redir_v;
  logic [XLEN-1:0]   redir;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_nxt       = state;
    pend_flush_nxt  = pend_flush;
    pend_pc_nxt     = pend_pc;
    if_id_valid_nxt = if_id_valid;
    id_ex_valid_nxt = id_ex_valid;
    flush_applied   = 1'b0;
    run_decode      = 1'b0;
    pc_we           = 1'b0;
    if_we           = 1'b0;
    id_we           = 1'b0;
    exm_we          = 1'b0;
    redir_v         = 1'b0;
    redir           = redirect_pc;

    case (state)
      RUN: begin
        if (flush_pipeline && dmem_ready) begin
          redir_v         = 1'b1;
          pc_we           = 1'b1;
          if_we           = 1'b1;
          id_we           = 1'b1;
          exm_we          = 1'b1;
          if_id_valid_nxt = 1'b0;
          id_ex_valid_nxt = 1'b0;
          flush_applied   = 1'b1;
        end else if (!dmem_ready) begin
          state_nxt = MEM_WAIT;
          if (flush_pipeline) begin
            pend_flush_nxt = 1'b1;
            pend_pc_nxt    = redirect_pc;
          end
        end else begin
          run_decode = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Earliest flush request during the wait is the one that gets applied.
        if (flush_pipeline && !pend_flush) begin
          pend_flush_nxt = 1'b1;
          pend_pc_nxt    = redirect_pc;
        end
        if (dmem_ready) begin
          run_decode = 1'b1;
          state_nxt  = (pend_flush || flush_pipeline) ? FLUSH_APPLY : RUN;
        end
      end
      FLUSH_APPLY: begin
        redir_v         = 1'b1;
        redir           = pend_pc;
        pc_we           = 1'b1;
        if_we           = 1'b1;
        id_we           = 1'b1;
        exm_we          = 1'b1;
        if_id_valid_nxt = 1'b0;
        id_ex_valid_nxt = 1'b0;
        pend_flush_nxt  = 1'b0;
        flush_applied   = 1'b1;
        state_nxt       = RUN;
      end
      default: state_nxt = RUN;
    endcase

    // Shared non-flush decode: load-use stall, then fetch wait, then normal.
    if (run_decode) begin
      id_we  = 1'b1;
      exm_we = 1'b1;
      if (stall_pipeline) begin
        id_ex_valid_nxt = 1'b0;
      end else if (!imem_ready) begin
        if_we           = 1'b1;
        if_id_valid_nxt = 1'b0;
        id_ex_valid_nxt = if_id_valid;
      end else begin
        pc_we           = 1'b1;
        if_we           = 1'b1;
        if_id_valid_nxt = 1'b1;
        id_ex_valid_nxt = if_id_valid;
      end
    end
  end

  assign pc_write_en       = rst_n & pc_we;
  assign if_id_write_en    = rst_n & if_we;
  assign id_ex_write_en    = rst_n & id_we;
  assign ex_mem_write_en   = rst_n & exm_we;
  assign pc_redirect_valid = rst_n & redir_v;
  assign pc_redirect       = redir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pend_flush   <= 1'b0;
      pend_pc      <= '0;
      if_id_valid  <= 1'b0;
      id_ex_valid  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state       <= state_nxt;
      pend_flush  <= pend_flush_nxt;
      pend_pc     <= pend_pc_nxt;
      if_id_valid <= if_id_valid_nxt;
      id_ex_valid <= id_ex_valid_nxt;
      if (!pc_we)        stall_cycles <= sat_inc(stall_cycles);
      if (flush_applied) flush_count  <= sat_inc(flush_count);
    end
  end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl; 4-bit counters make saturation reachable.
module tb_pipeline_flow_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall_pipeline, flush_pipeline, imem_ready, dmem_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic             pc_write_en, pc_redirect_valid;
  logic [XLEN-1:0]  pc_redirect;
  logic             if_id_write_en, id_ex_write_en, ex_mem_write_en;
  logic             if_id_valid, id_ex_valid;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_flow_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_pipeline(stall_pipeline), .flush_pipeline(flush_pipeline),
    .redirect_pc(redirect_pc), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write_en(pc_write_en), .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect(pc_redirect), .if_id_write_en(if_id_write_en),
    .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
    .if_id_valid(if_id_valid), .id_ex_valid(id_ex_valid),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] rpc,
                       input logic im, input logic dm);
    stall_pipeline = s;
    flush_pipeline = f;
    redirect_pc    = rpc;
    imem_ready     = im;
    dmem_ready     = dm;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enables(input string tag, input logic [3:0] exp);
    chk(tag, {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en}, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 1);
    #22;
    chk("rst_en",     {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en}, 0);
    chk("rst_redir",  pc_redirect_valid, 0);
    chk("rst_valids", {if_id_valid, id_ex_valid}, 0);
    chk("rst_cnt",    {stall_cycles, flush_count}, 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 1);
    enables("first_fetch", 4'b1111);
    tick;
    chk("fill_ifid", {if_id_valid, id_ex_valid}, 2'b10);
    tick;
    chk("fill_idex", {if_id_valid, id_ex_valid}, 2'b11);
    chk("no_stall_yet", stall_cycles, 0);

    // Load-use stall for one cycle
    drive(1, 0, 0, 1, 1);
    enables("lu_en", 4'b0011);
    tick;
    chk("lu_valids", {if_id_valid, id_ex_valid}, 2'b10);
    chk("lu_cnt", stall_cycles, 1);
    drive(0, 0, 0, 1, 1);
    tick;
    chk("lu_recover", {if_id_valid, id_ex_valid}, 2'b11);

    // Branch flush
    drive(0, 1, 32'h100, 1, 1);
    chk("br_rv", pc_redirect_valid, 1);
    chk("br_pc", pc_redirect, 32'h100);
    enables("br_en", 4'b1111);
    tick;
    chk("br_valids", {if_id_valid, id_ex_valid}, 2'b00);
    chk("br_fcnt", flush_count, 1);
    drive(0, 0, 0, 1, 1);
    chk("br_after_rv", pc_redirect_valid, 0);
    tick;
    tick;
    chk("br_refill", {if_id_valid, id_ex_valid}, 2'b11);

    // Flush and stall together: flush wins
    drive(1, 1, 32'h140, 1, 1);
    chk("fs_pcwe", pc_write_en, 1);
    chk("fs_rv", pc_redirect_valid, 1);
    chk("fs_pc", pc_redirect, 32'h140);
    tick;
    chk("fs_scnt", stall_cycles, 1);
    chk("fs_fcnt", flush_count, 2);
    drive(0, 0, 0, 1, 1);
    tick;
    tick;

    // dmem wait of 3 cycles, flush 0x200 in wait cycle 2
    drive(0, 0, 0, 1, 0);
    enables("mw1_en", 4'b0000);
    tick;
    chk("mw1_scnt", stall_cycles, 2);
    drive(0, 1, 32'h200, 1, 0);
    enables("mw2_en", 4'b0000);
    chk("mw2_rv", pc_redirect_valid, 0);
    tick;
    drive(0, 0, 32'h3fc, 1, 0);
    enables("mw3_en", 4'b0000);
    tick;
    chk("mw3_scnt", stall_cycles, 4);
    drive(0, 0, 32'h3fc, 1, 1);
    chk("mwr_rv", pc_redirect_valid, 0);
    enables("mwr_en", 4'b1111);
    chk("mwr_fcnt", flush_count, 2);
    tick;
    chk("fa_rv", pc_redirect_valid, 1);
    chk("fa_pc", pc_redirect, 32'h200);
    chk("fa_pcwe", pc_write_en, 1);
    tick;
    chk("fa_valids", {if_id_valid, id_ex_valid}, 2'b00);
    chk("fa_fcnt", flush_count, 3);
    chk("fa_rv_done", pc_redirect_valid, 0);
    tick;
    tick;
    chk("pre_im_valids", {if_id_valid, id_ex_valid}, 2'b11);

    // Two imem wait cycles
    drive(0, 0, 0, 0, 1);
    chk("im_pcwe", pc_write_en, 0);
    tick;
    chk("im1_valids", {if_id_valid, id_ex_valid}, 2'b01);
    tick;
    chk("im2_valids", {if_id_valid, id_ex_valid}, 2'b00);
    chk("im_scnt", stall_cycles, 6);
    drive(0, 0, 0, 1, 1);
    tick;
    chk("im3_valids", {if_id_valid, id_ex_valid}, 2'b10);
    tick;
    chk("im4_valids", {if_id_valid, id_ex_valid}, 2'b11);

    // Async reset during MEM_WAIT with a pending flush
    drive(0, 1, 32'h300, 1, 0);
    tick;
    drive(0, 0, 0, 1, 0);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_en", {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en}, 0);
    chk("ar_rv", pc_redirect_valid, 0);
    chk("ar_valids", {if_id_valid, id_ex_valid}, 0);
    chk("ar_cnt", {stall_cycles, flush_count}, 0);
    drive(0, 0, 0, 1, 1);
    rst_n = 1'b1;
    #1;
    chk("ar_rel_rv", pc_redirect_valid, 0);
    enables("ar_rel_en", 4'b1111);
    tick;
    chk("ar_post_rv", pc_redirect_valid, 0);
    chk("ar_post_fcnt", flush_count, 0);
    chk("ar_post_ifid", if_id_valid, 1);

    // Counter saturation
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) tick;
    chk("sat_scnt", stall_cycles, 15);
    drive(0, 1, 32'h40, 1, 1);
    for (int i = 0; i < 17; i++) tick;
    chk("sat_fcnt", flush_count, 15);
    chk("sat_scnt_hold", stall_cycles, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
